sw_led_io: RTL and testbench
============================

Name: sw_led_io

Overview:
- Memory-mapped I/O responder for the simple RISC CPU's data-memory bus.
- Switch side: synchronises and debounces the board switches, flags switch changes, and returns both on CPU reads.
- LED side: latches CPU writes onto the LED outputs.
- Sits beside the RAM in the top level and answers only its own addresses; all other bus traffic is ignored.

Parameters:
- N_SW, 10, number of switch inputs (max 16)
- N_LED, 8, number of CPU-writable LED outputs (max 16)
- DEBOUNCE_CYCLES, 4, consecutive cycles a new level must persist before it is accepted (>=1; 500000 on board)
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1
- SW_ADDR, 9'h140, address of the switch data register (read-only)
- EVT_ADDR, 9'h141, address of the switch change-event register (read, clear-on-read)
- LED_ADDR, 9'h100, address of the LED register (write-only)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- mem_cmd  in  2  bus command: 00 none, 01 read, 10 write, 11 treated as none
- mem_addr  in  9  bus address
- write_data  in  16  bus write data
- sw_in  in  N_SW  raw asynchronous switches
- read_data  out  16  registered read result
- rd_valid  out  1  one-cycle pulse: read_data holds a fresh response
- led_out  out  N_LED  LED register
- sw_stable  out  N_SW  debounced switch levels (for top-level status use)

Behaviour:
- Reset (sync, active-high): sync flops, sw_stable, event register, all counters, led_out, read_data and rd_valid go to 0.
  - Reset has priority over any same-cycle bus command or switch change.
  - Reset asserted mid-debounce discards the partial count.
- Synchroniser: two flops per bit, giving sync2.
- Debounce, per bit, one independent counter each:
  - sync2 == sw_stable: counter clears to 0.
  - Mismatch with counter < DEBOUNCE_CYCLES-1: counter increments.
  - Mismatch with counter == DEBOUNCE_CYCLES-1: sw_stable toggles and the counter clears.
  - Latency: a level presented before edge k and held appears on sw_stable at edge k+1+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES cycles in sync2 never changes sw_stable.
- Event register, per bit:
  - Set to 1 on the edge where sw_stable toggles, in either direction.
  - Sticky until read.
- Read of EVT_ADDR:
  - read_data = zero-extended event register.
  - The event register clears on that same edge.
  - A bit toggling on the read edge stays 1 afterward (set beats clear) and is also returned as 1.
- Read of SW_ADDR: read_data = zero-extended sw_stable value before the edge. No side effects.
- Read timing:
  - read_data is captured on the edge that samples the read; rd_valid = 1 for the following cycle.
  - read_data holds its value until the next decoded read.
  - Back-to-back reads give one response per cycle.
- Write to LED_ADDR: led_out <= write_data[N_LED-1:0] on that edge; visible the next cycle.
- Ignored bus accesses:
  - Writes to SW_ADDR or EVT_ADDR.
  - Reads of LED_ADDR.
  - Any other address or command 00/11.
  - For all of these, rd_valid = 0 and no state changes.
- Unused upper read_data bits are always 0.

Test Plan:
- Reset with sw_in=10'h3FF held: after reset, led_out=0, rd_valid=0, sw_stable=0. Release reset at edge r: sw_stable=10'h3FF at edge r+5 (D=4); read EVT_ADDR returns 16'h03FF, and a second read returns 16'h0000.
- sw_in=10'b0000101001 held, then read SW_ADDR after settling -> next cycle rd_valid=1, read_data=16'h0029; the cycle after, rd_valid=0 and read_data is still 16'h0029.
- Glitch sw_in[3] high for 3 cycles (D=4) -> sw_stable[3] stays 0 and EVT_ADDR reads 0. Hold high for 4 or more cycles -> sw_stable[3]=1 and EVT_ADDR reads 16'h0008.
- Write LED_ADDR with write_data=16'hABCD -> led_out=8'hCD next cycle. Write 16'h1234 to SW_ADDR -> led_out, sw_stable and event register unchanged.
- EVT_ADDR read on the exact edge sw_stable[0] toggles -> read returns bit0=1 and the event register retains bit0=1 afterwards.
- Assert reset for one cycle mid-debounce, with counter at 2 -> counter restarts from 0 and sw_stable is delayed by the full DEBOUNCE_CYCLES after reset release; led_out=0.

Source files
------------

// File: rtl/sw_led_io_if.sv
// Data-memory bus bundle between the CPU and the switch/LED responder.
// Command encoding: 00 none, 01 read, 10 write, 11 none.
interface sw_led_io_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        rd_valid;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data,
        input  rd_valid
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data,
        output rd_valid
    );
endinterface

// File: rtl/sw_led_io.sv
// Memory-mapped switch/LED responder: synchronised, debounced switches with
// sticky change events, plus a CPU-writable LED register.
module sw_led_io #(
    parameter int          N_SW            = 10,
    parameter int          N_LED           = 8,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          CNT_W           = 20,
    parameter logic [8:0]  SW_ADDR         = 9'h140,
    parameter logic [8:0]  EVT_ADDR        = 9'h141,
    parameter logic [8:0]  LED_ADDR        = 9'h100
) (
    input  logic             clk,
    input  logic             reset,
    sw_led_io_if.slave       bus,
    input  logic [N_SW-1:0]  sw_in,
    output logic [N_LED-1:0] led_out,
    output logic [N_SW-1:0]  sw_stable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  sync1_q, sync2_q;
    logic [N_SW-1:0]  stable_q, stable_d;
    logic [N_SW-1:0]  evt_q, evt_d;
    logic [N_SW-1:0]  toggle;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];
    logic [N_LED-1:0] led_q, led_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             rd_sw, rd_evt, wr_led;
    logic [15:0]      unused_wdata;

    assign rd_sw  = (bus.mem_cmd == 2'b01) && (bus.mem_addr == SW_ADDR);
    assign rd_evt = (bus.mem_cmd == 2'b01) && (bus.mem_addr == EVT_ADDR);
    assign wr_led = (bus.mem_cmd == 2'b10) && (bus.mem_addr == LED_ADDR);
    assign unused_wdata = bus.write_data;

    always_comb begin
        toggle = '0;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        stable_d = stable_q ^ toggle;
        // A toggle landing on the clearing read wins and is reported too
        evt_d    = (rd_evt ? '0 : evt_q) | toggle;
        led_d    = wr_led ? bus.write_data[N_LED-1:0] : led_q;
        rvalid_d = rd_sw || rd_evt;
        rdata_d  = rdata_q;
        if (rd_sw) begin
            rdata_d = '0;
            rdata_d[N_SW-1:0] = stable_q;
        end else if (rd_evt) begin
            rdata_d = '0;
            rdata_d[N_SW-1:0] = evt_q | toggle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            evt_q    <= '0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
            led_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            sync1_q  <= sw_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            evt_q    <= evt_d;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            led_q    <= led_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.read_data = rdata_q;
    assign bus.rd_valid  = rvalid_q;
    assign led_out       = led_q;
    assign sw_stable     = stable_q;

endmodule

// File: tb/tb_sw_led_io.sv
// Bench for sw_led_io: bus vector table plus hand-written debounce,
// clear-on-read and reset sequences, with a read-response scoreboard.
module tb_sw_led_io;

    localparam logic [8:0] SW_A  = 9'h140;
    localparam logic [8:0] EVT_A = 9'h141;
    localparam logic [8:0] LED_A = 9'h100;

    logic       clk;
    logic       reset;
    logic [9:0] sw_in;
    logic [7:0] led_out;
    logic [9:0] sw_stable;

    sw_led_io_if bus ();

    sw_led_io dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .sw_stable (sw_stable)
    );

    typedef struct {
        logic [15:0] data;
        int          due;
    } rsp_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic        rsp;
        logic [15:0] exp_rd;
        logic [7:0]  exp_led;
    } vec_t;

    rsp_t sb[$];
    vec_t tbl[13];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Response checker: a read is due exactly one cycle after it is driven
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("rd_valid pulse", {31'b0, bus.rd_valid}, 32'd1);
            chk("read_data", {16'b0, bus.read_data}, {16'b0, sb[0].data});
            void'(sb.pop_front());
        end else begin
            chk("rd_valid idle", {31'b0, bus.rd_valid}, 32'd0);
        end
    end

    task automatic rd(input logic [8:0] addr, input logic [15:0] exp);
        @(negedge clk);
        bus.mem_cmd  = 2'b01;
        bus.mem_addr = addr;
        sb.push_back('{data: exp, due: cyc + 1});
        @(negedge clk);
        bus.mem_cmd  = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{2'b10, LED_A,  16'hABCD, 1'b0, 16'h0000, 8'hCD};
        tbl[1]  = '{2'b10, SW_A,   16'h1234, 1'b0, 16'h0000, 8'hCD};
        tbl[2]  = '{2'b01, SW_A,   16'h0000, 1'b1, 16'h000A, 8'hCD};
        tbl[3]  = '{2'b01, LED_A,  16'h0000, 1'b0, 16'h0000, 8'hCD};
        tbl[4]  = '{2'b10, EVT_A,  16'hFFFF, 1'b0, 16'h0000, 8'hCD};
        tbl[5]  = '{2'b11, LED_A,  16'h5555, 1'b0, 16'h0000, 8'hCD};
        tbl[6]  = '{2'b01, 9'h142, 16'h0000, 1'b0, 16'h0000, 8'hCD};
        tbl[7]  = '{2'b10, LED_A,  16'h1F0F, 1'b0, 16'h0000, 8'h0F};
        tbl[8]  = '{2'b01, SW_A,   16'h0000, 1'b1, 16'h000A, 8'h0F};
        tbl[9]  = '{2'b01, SW_A,   16'h0000, 1'b1, 16'h000A, 8'h0F};
        tbl[10] = '{2'b10, 9'h000, 16'h7777, 1'b0, 16'h0000, 8'h0F};
        tbl[11] = '{2'b00, LED_A,  16'h3C3C, 1'b0, 16'h0000, 8'h0F};
        tbl[12] = '{2'b10, LED_A,  16'h00F0, 1'b0, 16'h0000, 8'hF0};

        reset          = 1'b1;
        sw_in          = 10'h3FF;
        bus.mem_cmd    = 2'b00;
        bus.mem_addr   = 9'h000;
        bus.write_data = 16'h0000;

        // Reset with all switches high, then full debounce latency
        repeat (3) @(negedge clk);
        chk("reset led_out", {24'b0, led_out}, 32'h0);
        chk("reset sw_stable", {22'b0, sw_stable}, 32'h0);
        chk("reset read_data", {16'b0, bus.read_data}, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("latency r+4", {22'b0, sw_stable}, 32'h0);
        @(negedge clk);
        chk("latency r+5", {22'b0, sw_stable}, 32'h3FF);
        rd(EVT_A, 16'h03FF);
        rd(EVT_A, 16'h0000);

        // Switch pattern read and read_data hold
        sw_in = 10'b0000101001;
        repeat (8) @(negedge clk);
        rd(EVT_A, 16'h03FF ^ 16'h0029);
        rd(SW_A, 16'h0029);
        @(negedge clk);
        chk("read_data hold", {16'b0, bus.read_data}, 32'h0029);

        // Short glitch on bit 3 is rejected, a long one is accepted
        sw_in = 10'h000;
        repeat (8) @(negedge clk);
        rd(EVT_A, 16'h0029);
        @(negedge clk);
        sw_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        sw_in[3] = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch sw_stable", {22'b0, sw_stable}, 32'h0);
        rd(EVT_A, 16'h0000);
        sw_in[3] = 1'b1;
        repeat (8) @(negedge clk);
        chk("held sw_stable", {22'b0, sw_stable}, 32'h008);
        rd(EVT_A, 16'h0008);

        // Bus vector table with an event pending on bit 1
        sw_in = 10'h00A;
        repeat (8) @(negedge clk);
        chk("pre-table sw_stable", {22'b0, sw_stable}, 32'h00A);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("tbl%0d led_out", i - 1), {24'b0, led_out},
                    {24'b0, tbl[i-1].exp_led});
                chk($sformatf("tbl%0d sw_stable", i - 1),
                    {22'b0, sw_stable}, 32'h00A);
            end
            bus.mem_cmd    = tbl[i].cmd;
            bus.mem_addr   = tbl[i].addr;
            bus.write_data = tbl[i].wdata;
            if (tbl[i].rsp) sb.push_back('{data: tbl[i].exp_rd, due: cyc + 1});
        end
        @(negedge clk);
        chk("tbl12 led_out", {24'b0, led_out}, {24'b0, tbl[12].exp_led});
        bus.mem_cmd = 2'b00;
        rd(EVT_A, 16'h0002);

        // Clear-on-read on the exact toggle edge of bit 0
        @(negedge clk);
        sw_in = 10'h00B;
        repeat (4) @(negedge clk);
        chk("pre-toggle sw_stable", {22'b0, sw_stable}, 32'h00A);
        rd(EVT_A, 16'h0001);
        chk("post-toggle sw_stable", {22'b0, sw_stable}, 32'h00B);
        rd(EVT_A, 16'h0001);
        rd(EVT_A, 16'h0000);

        // Reset mid-debounce with bit 0 counter at 2
        @(negedge clk);
        sw_in = 10'h00A;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset led_out", {24'b0, led_out}, 32'h0);
        chk("mid reset sw_stable", {22'b0, sw_stable}, 32'h0);
        chk("mid reset read_data", {16'b0, bus.read_data}, 32'h0);
        repeat (5) @(negedge clk);
        chk("re-latency r+4", {22'b0, sw_stable}, 32'h0);
        @(negedge clk);
        chk("re-latency r+5", {22'b0, sw_stable}, 32'h00A);
        chk("post reset led_out", {24'b0, led_out}, 32'h0);
        rd(EVT_A, 16'h000A);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
